// File: rtl/timer99_ctrl.sv
// Two-button 0..99 countdown timer feeding the two-digit 7-segment decoder.
// Optional DONE-state display blinking is built when TIMER99_BLINK_EN is defined.
module timer99_ctrl #(
   parameter int TICK_DIV  = 50_000_000,
   parameter int INIT_VAL  = 99,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_start_n,
   input  logic       key_load_n,
   input  logic [6:0] load_val,
   output logic [7:0] data,
   output logic       running,
   output logic       done
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [6:0] INIT_CNT = 7'(INIT_VAL);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t state, state_nx;
   logic [6:0] count, count_nx, reload, reload_nx, lv;
   logic [PW-1:0] presc, presc_nx;
   logic start_s1, start_s2, start_prev;
   logic load_s1, load_s2, load_prev;
   logic start_press, load_press;
   logic blank;
   logic [7:0] data_nx;

   // Buttons are asynchronous: two sync flops, then a previous-level flop to find the press edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_s1   <= 1'b1;
         start_s2   <= 1'b1;
         start_prev <= 1'b1;
         load_s1    <= 1'b1;
         load_s2    <= 1'b1;
         load_prev  <= 1'b1;
      end else begin
         start_s1   <= key_start_n;
         start_s2   <= start_s1;
         start_prev <= start_s2;
         load_s1    <= key_load_n;
         load_s2    <= load_s1;
         load_prev  <= load_s2;
      end
   end

   assign start_press = start_prev & ~start_s2;
   assign load_press  = load_prev & ~load_s2;
   assign lv          = (load_val > 7'd99) ? 7'd99 : load_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         count  <= INIT_CNT;
         reload <= INIT_CNT;
         presc  <= '0;
      end else begin
         state  <= state_nx;
         count  <= count_nx;
         reload <= reload_nx;
         presc  <= presc_nx;
      end
   end

   // Load has priority over start; otherwise each state reacts to a start press or a tick.
   always_comb begin
      state_nx  = state;
      count_nx  = count;
      reload_nx = reload;
      presc_nx  = presc;
      if (load_press) begin
         state_nx  = IDLE;
         count_nx  = lv;
         reload_nx = lv;
         presc_nx  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_press) begin
                  state_nx = RUN;
                  presc_nx = '0;
               end
            end
            RUN: begin
               if (start_press) begin
                  state_nx = PAUSE;
               end else if (count == 7'd0) begin
                  state_nx = DONE;
               end else if (presc == TICK_LAST) begin
                  presc_nx = '0;
                  count_nx = count - 7'd1;
                  if (count == 7'd1) begin
                     state_nx = DONE;
                  end
               end else begin
                  presc_nx = presc + PW'(1);
               end
            end
            PAUSE: begin
               if (start_press) begin
                  state_nx = RUN;
               end
            end
            DONE: begin
               count_nx = 7'd0;
               if (start_press) begin
                  state_nx = IDLE;
                  count_nx = reload;
               end
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

`ifdef TIMER99_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [BW-1:0] blink_cnt, blink_cnt_nx;
   logic phase, phase_nx;

   // Phase only advances while staying in DONE, so entry starts unblanked and exit clears it.
   always_comb begin
      blink_cnt_nx = '0;
      phase_nx     = 1'b0;
      if (state == DONE && state_nx == DONE) begin
         if (blink_cnt == BLINK_LAST) begin
            phase_nx = ~phase;
         end else begin
            blink_cnt_nx = blink_cnt + BW'(1);
            phase_nx     = phase;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else begin
         blink_cnt <= blink_cnt_nx;
         phase     <= phase_nx;
      end
   end

   assign blank = (state_nx == DONE) & phase_nx;
`else
   assign blank = 1'b0;
`endif

   assign data_nx = blank ? 8'hFF : {1'b0, count_nx};

   // Outputs are registered from next-state values so they change on the same edge as state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data    <= {1'b0, INIT_CNT};
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         data    <= data_nx;
         running <= (state_nx == RUN);
         done    <= (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_timer99_ctrl.sv
// Scoreboard bench for timer99_ctrl: a behavioural model predicts every cycle's outputs,
// a monitor process pops and compares them after each rising edge.
module tb_timer99_ctrl;

   localparam int TD = 4;
   localparam int BD = 3;
   localparam int IV = 99;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;
`ifdef TIMER99_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_start_n = 1'b1;
   logic       key_load_n = 1'b1;
   logic [6:0] load_val = 7'd0;
   logic [7:0] data;
   logic       running;
   logic       done;

   typedef struct {
      logic [7:0] data;
      logic       running;
      logic       done;
   } exp_t;

   exp_t sb[$];
   int compared = 0;
   int mismatched = 0;

   int m_mode, m_count, m_reload, m_elapsed, m_done_cyc;
   logic [2:0] s_hist, l_hist;

   timer99_ctrl #(.TICK_DIV(TD), .INIT_VAL(IV), .BLINK_DIV(BD)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_start_n(key_start_n),
      .key_load_n(key_load_n),
      .load_val(load_val),
      .data(data),
      .running(running),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      m_mode     = M_IDLE;
      m_count    = IV;
      m_reload   = IV;
      m_elapsed  = 0;
      m_done_cyc = 0;
      s_hist     = 3'b111;
      l_hist     = 3'b111;
   endtask

   // A press acts on the third edge after the key is first sampled low (history bit 1 low, bit 2 high).
   task automatic modelStep(input logic ks, input logic kl, input logic [6:0] lv);
      logic sp, lp;
      int prev_mode;
      exp_t e;
      sp = s_hist[2] & ~s_hist[1];
      lp = l_hist[2] & ~l_hist[1];
      s_hist = {s_hist[1:0], ks};
      l_hist = {l_hist[1:0], kl};
      prev_mode = m_mode;
      if (lp) begin
         m_count   = (int'(lv) > 99) ? 99 : int'(lv);
         m_reload  = m_count;
         m_mode    = M_IDLE;
         m_elapsed = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (sp) begin m_mode = M_RUN; m_elapsed = 0; end
            M_RUN: begin
               if (sp) m_mode = M_PAUSE;
               else if (m_count == 0) m_mode = M_DONE;
               else begin
                  m_elapsed++;
                  if (m_elapsed == TD) begin
                     m_elapsed = 0;
                     m_count--;
                     if (m_count == 0) m_mode = M_DONE;
                  end
               end
            end
            M_PAUSE: if (sp) m_mode = M_RUN;
            default: if (sp) begin m_mode = M_IDLE; m_count = m_reload; end
         endcase
      end
      if (m_mode == M_DONE && prev_mode == M_DONE) m_done_cyc++;
      else m_done_cyc = 0;
      if (m_mode == M_DONE)
         e.data = (BLINK && ((m_done_cyc / BD) % 2 == 1)) ? 8'hFF : 8'd0;
      else
         e.data = 8'(m_count);
      e.running = (m_mode == M_RUN);
      e.done    = (m_mode == M_DONE);
      sb.push_back(e);
   endtask

   // Called at a falling edge: drive inputs, predict the next rising edge, move to the next falling edge.
   task automatic applyStimulus(input logic ks, input logic kl, input logic [6:0] lv);
      key_start_n = ks;
      key_load_n  = kl;
      load_val    = lv;
      modelStep(ks, kl, lv);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, load_val);
   endtask

   task automatic pressKeys(input logic s, input logic l, input logic [6:0] lv, input int hold);
      for (int i = 0; i < hold; i++) applyStimulus(~s, ~l, lv);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, lv);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] ed, input logic er,
                              input logic edn, input bit chk_data);
      compared++;
      if ((chk_data && data !== ed) || running !== er || done !== edn) begin
         mismatched++;
         $display("[TB] FAIL %s: got data=%0d running=%0b done=%0b, required data=%0d running=%0b done=%0b",
                  name, data, running, done, ed, er, edn);
      end
   endtask

   task automatic monitorCompare(input exp_t e);
      compared++;
      if (data !== e.data || running !== e.running || done !== e.done) begin
         mismatched++;
         $display("[TB] FAIL scoreboard @%0t: got data=%0d running=%0b done=%0b, required data=%0d running=%0b done=%0b",
                  $time, data, running, done, e.data, e.running, e.done);
      end
   endtask

   initial begin
      exp_t e;
      int r;
      modelReset();
      fork
         forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               monitorCompare(e);
            end
         end
      join_none

      repeat (2) @(negedge clk);
      checkOutput("reset_init", 8'd99, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      idle(2);

      // Load and clamp
      pressKeys(1'b0, 1'b1, 7'd42, 2);
      checkOutput("load42", 8'd42, 1'b0, 1'b0, 1'b1);
      pressKeys(1'b0, 1'b1, 7'd120, 1);
      checkOutput("load_clamp", 8'd99, 1'b0, 1'b0, 1'b1);

      // Countdown from 3 into DONE
      pressKeys(1'b0, 1'b1, 7'd3, 1);
      pressKeys(1'b1, 1'b0, 7'd3, 1);
      idle(20);
      checkOutput("countdown_done", 8'd0, 1'b0, 1'b1, !BLINK);

      // Pause and resume with the remaining prescaler cycles
      pressKeys(1'b0, 1'b1, 7'd9, 1);
      pressKeys(1'b1, 1'b0, 7'd9, 1);
      idle(2);
      pressKeys(1'b1, 1'b0, 7'd9, 1);
      idle(20);
      checkOutput("pause_frozen", 8'd8, 1'b0, 1'b0, 1'b1);
      pressKeys(1'b1, 1'b0, 7'd9, 1);
      checkOutput("resume", 8'd8, 1'b1, 1'b0, 1'b1);
      idle(1);
      checkOutput("resume_hold", 8'd8, 1'b1, 1'b0, 1'b1);
      idle(1);
      checkOutput("resume_tick", 8'd7, 1'b1, 1'b0, 1'b1);

      // Simultaneous start + load in RUN
      pressKeys(1'b1, 1'b1, 7'd10, 1);
      checkOutput("simultaneous", 8'd10, 1'b0, 1'b0, 1'b1);

      // Start from zero goes straight through RUN to DONE
      pressKeys(1'b0, 1'b1, 7'd0, 1);
      pressKeys(1'b1, 1'b0, 7'd0, 1);
      checkOutput("zero_start", 8'd0, 1'b0, 1'b1, 1'b1);

      // DONE then start reloads
      pressKeys(1'b0, 1'b1, 7'd2, 1);
      pressKeys(1'b1, 1'b0, 7'd2, 1);
      idle(15);
      checkOutput("done_reached", 8'd0, 1'b0, 1'b1, !BLINK);
      pressKeys(1'b1, 1'b0, 7'd2, 1);
      checkOutput("done_reload", 8'd2, 1'b0, 1'b0, 1'b1);

      // Async reset mid-RUN at 57
      pressKeys(1'b0, 1'b1, 7'd57, 1);
      pressKeys(1'b1, 1'b0, 7'd57, 1);
      idle(1);
      checkOutput("pre_reset_57", 8'd57, 1'b1, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 8'd99, 1'b0, 1'b0, 1'b1);
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Randomized presses checked by the scoreboard
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r < 3)
            pressKeys(1'b1, 1'b0, load_val, $urandom_range(1, 4));
         else if (r < 5)
            pressKeys(1'b0, 1'b1, 7'($urandom_range(0, 127)), $urandom_range(1, 3));
         else if (r == 5)
            pressKeys(1'b1, 1'b1, 7'($urandom_range(0, 20)), 1);
         else
            idle($urandom_range(1, 12));
      end

      @(posedge clk);
      #2;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
